// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M instruction decoder: encodings, funct3 names
// and the control bundle handed to the multiplier/divider datapaths.
package rv32m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef struct packed {
    logic mult_on;
    logic div_on;
    logic signed_A;
    logic signed_B;
    logic upper_rem;
  } ctrl_t;

  // An illegal encoding yields an all-zero bundle so neither unit is selected.
  function automatic ctrl_t decode_ctrl(input logic [2:0] funct3, input logic legal);
    ctrl_t c;
    c = '0;
    if (legal) begin
      case (funct3_e'(funct3))
        F3_MUL:    c = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        F3_MULH:   c = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        F3_MULHSU: c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        F3_MULHU:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        F3_DIV:    c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        F3_DIVU:   c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        F3_REM:    c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        F3_REMU:   c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        default:   c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rv32m_decoder_if.sv
// Instruction-field inputs and decoded controls between dispatch (master) and
// the RV32M decoder (slave).
interface rv32m_decoder_if;

  logic       en_i;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;

  logic mult_on_o;
  logic div_on_o;
  logic signed_A_o;
  logic signed_B_o;
  logic upper_rem_o;

  logic valid_q_o;
  logic mult_on_q_o;
  logic div_on_q_o;
  logic signed_A_q_o;
  logic signed_B_q_o;
  logic upper_rem_q_o;

  modport master (
    output en_i, opcode_i, funct3_i, funct7_i,
    input  mult_on_o, div_on_o, signed_A_o, signed_B_o, upper_rem_o,
    input  valid_q_o, mult_on_q_o, div_on_q_o, signed_A_q_o, signed_B_q_o, upper_rem_q_o
  );

  modport slave (
    input  en_i, opcode_i, funct3_i, funct7_i,
    output mult_on_o, div_on_o, signed_A_o, signed_B_o, upper_rem_o,
    output valid_q_o, mult_on_q_o, div_on_q_o, signed_A_q_o, signed_B_q_o, upper_rem_q_o
  );

endinterface

// File: rtl/rv32m_decoder.sv
// RV32M decoder: combinational unit/signedness controls plus an enable-qualified
// registered copy for the accelerator issue stage.
module rv32m_decoder
  import rv32m_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  rv32m_decoder_if.slave bus
);

  logic  w_legal;
  ctrl_t w_ctrl;
  ctrl_t r_ctrl;
  logic  r_valid;

  always_comb begin
    w_legal = (bus.opcode_i == OPCODE_OP) && (bus.funct7_i == FUNCT7_MULDIV);
    w_ctrl  = decode_ctrl(bus.funct3_i, w_legal);
  end

  // Illegal encodings are captured as zeros rather than holding the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (bus.en_i) begin
      r_valid <= w_legal;
      r_ctrl  <= w_ctrl;
    end
  end

  assign bus.mult_on_o   = w_ctrl.mult_on;
  assign bus.div_on_o    = w_ctrl.div_on;
  assign bus.signed_A_o  = w_ctrl.signed_A;
  assign bus.signed_B_o  = w_ctrl.signed_B;
  assign bus.upper_rem_o = w_ctrl.upper_rem;

  assign bus.valid_q_o     = r_valid;
  assign bus.mult_on_q_o   = r_ctrl.mult_on;
  assign bus.div_on_q_o    = r_ctrl.div_on;
  assign bus.signed_A_q_o  = r_ctrl.signed_A;
  assign bus.signed_B_q_o  = r_ctrl.signed_B;
  assign bus.upper_rem_q_o = r_ctrl.upper_rem;

endmodule

// File: tb/tb_rv32m_decoder.sv
// Scoreboard bench for rv32m_decoder: directed vectors push expected outputs,
// a negedge monitor pops and compares against the DUT.
module tb_rv32m_decoder;

  logic clk_i;
  logic rst_ni;

  rv32m_decoder_if bus ();

  rv32m_decoder dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Expected vector: {valid_q, mult_q, div_q, sA_q, sB_q, ur_q, mult, div, sA, sB, ur}
  logic [10:0] exp_q[$];
  string       name_q[$];

  // Bench model of the register stage, driven by hand-computed comb rows.
  logic [5:0] m_reg;
  logic       m_en;
  logic [4:0] m_comb;

  localparam logic [6:0] OP_LEGAL = 7'b0110011;
  localparam logic [6:0] F7_LEGAL = 7'b0000001;

  logic [10:0] act;
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {bus.valid_q_o, bus.mult_on_q_o, bus.div_on_q_o, bus.signed_A_q_o,
             bus.signed_B_q_o, bus.upper_rem_q_o, bus.mult_on_o, bus.div_on_o,
             bus.signed_A_o, bus.signed_B_o, bus.upper_rem_o};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
      total++;
      if ((bus.mult_on_o & bus.div_on_o) !== 1'b0) begin
        bad++;
        $display("FAIL %s_excl: mult&div got %b expected 0", n, bus.mult_on_o & bus.div_on_o);
      end
    end
  end

  task automatic push(input string n);
    exp_q.push_back({m_reg, m_comb});
    name_q.push_back(n);
  endtask

  task automatic edge_model();
    @(posedge clk_i);
    if (rst_ni && m_en) m_reg = {(m_comb[4] | m_comb[3]), m_comb};
  endtask

  task automatic step(input string n, input logic en, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] exp5);
    edge_model();
    #1;
    bus.en_i     = en;
    bus.opcode_i = op;
    bus.funct3_i = f3;
    bus.funct7_i = f7;
    m_en   = en;
    m_comb = exp5;
    push(n);
  endtask

  // Rows (mult, div, sA, sB, ur) worked out by hand from the instruction table.
  logic [4:0] rows [8];
  initial begin
    rows[0] = 5'b10110; rows[1] = 5'b10111; rows[2] = 5'b10101; rows[3] = 5'b10001;
    rows[4] = 5'b01110; rows[5] = 5'b01000; rows[6] = 5'b01111; rows[7] = 5'b01001;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    bus.en_i     = 1'b0;
    bus.opcode_i = '0;
    bus.funct3_i = '0;
    bus.funct7_i = '0;
    m_reg  = '0;
    m_en   = 1'b0;
    m_comb = '0;

    // Held in reset: comb path still decodes, registers stay 0 even with en high.
    step("rst_comb", 1'b1, OP_LEGAL, 3'b001, F7_LEGAL, 5'b10111);
    step("rst_hold", 1'b0, 7'b0111011, 3'b000, F7_LEGAL, 5'b00000);
    edge_model();
    #1 rst_ni = 1'b1;

    step("bad_opcode", 1'b0, 7'b0111011, 3'b000, F7_LEGAL,   5'b00000);
    step("bad_funct7", 1'b0, OP_LEGAL,   3'b000, 7'b0100001, 5'b00000);
    step("bad_both",   1'b0, 7'b0000011, 3'b100, 7'b0100000, 5'b00000);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] f3;
      f3 = 3'(i);
      step($sformatf("sweep_f3_%0d", i), 1'b1, OP_LEGAL, f3, F7_LEGAL, rows[i]);
    end

    step("mulh_set",   1'b1, OP_LEGAL, 3'b001, F7_LEGAL, 5'b10111);
    step("div_noen_a", 1'b0, OP_LEGAL, 3'b100, F7_LEGAL, 5'b01110);
    step("div_noen_b", 1'b0, OP_LEGAL, 3'b100, F7_LEGAL, 5'b01110);

    // Async reset between edges right after a legal capture.
    step("mulhsu_set", 1'b1, OP_LEGAL, 3'b010, F7_LEGAL, 5'b10101);
    edge_model();
    #1 push("mulhsu_captured");
    edge_model();
    #3 rst_ni = 1'b0;
    m_reg = '0;
    push("async_rst");
    edge_model();
    #1 rst_ni = 1'b1;
    push("rst_low_edge");

    step("rem_set",      1'b1, OP_LEGAL, 3'b110, F7_LEGAL,   5'b01111);
    step("illegal_set",  1'b1, OP_LEGAL, 3'b110, 7'b0000011, 5'b00000);
    step("illegal_cap",  1'b0, OP_LEGAL, 3'b110, 7'b0000011, 5'b00000);
    step("remu_cap_set", 1'b1, OP_LEGAL, 3'b111, F7_LEGAL,   5'b01001);
    step("remu_cap",     1'b0, OP_LEGAL, 3'b111, F7_LEGAL,   5'b01001);

    repeat (3) @(posedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32m_decoder.md
# rv32m_decoder

Instruction decoder for the RV32M multiply/divide accelerator. It identifies the eight M-extension R-type instructions and emits unit-select, operand-signedness and result-half/remainder controls. Outputs are available combinationally for same-cycle use and as a registered copy for the accelerator's issue stage. It sits between instruction fetch/dispatch and the multiplier/divider datapaths.

## Interface
No parameters. Clocking: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock, rising-edge
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  capture enable for registered outputs
- opcode_i  in  7  instruction[6:0]
- funct3_i  in  3  instruction[14:12]
- funct7_i  in  7  instruction[31:25]
- mult_on_o  out  1  comb: select multiplier
- div_on_o  out  1  comb: select divider
- signed_A_o  out  1  comb: operand A (rs1) signed
- signed_B_o  out  1  comb: operand B (rs2) signed
- upper_rem_o  out  1  comb: multiplier returns high word / divider returns remainder
- valid_q_o  out  1  reg: captured instruction was a legal M op
- mult_on_q_o, div_on_q_o, signed_A_q_o, signed_B_q_o, upper_rem_q_o  out  1 each  registered copies of the comb outputs

## Operation
- legal = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001). Any other opcode or funct7 -> all five comb outputs 0.
- When legal, by funct3_i (mult_on, div_on, signed_A, signed_B, upper_rem):
- 000 MUL: 1,0,1,1,0
- 001 MULH: 1,0,1,1,1
- 010 MULHSU: 1,0,1,0,1
- 011 MULHU: 1,0,0,0,1
- 100 DIV: 0,1,1,1,0
- 101 DIVU: 0,1,0,0,0
- 110 REM: 0,1,1,1,1
- 111 REMU: 0,1,0,0,1
- Invariants: mult_on_o & div_on_o == 0 always; mult_on_o | div_on_o == legal.
- Comb outputs are purely combinational in opcode/funct3/funct7; independent of clk_i, rst_ni, en_i.
- Registered path: on rising clk_i with en_i=1, capture legal into valid_q_o and the five comb outputs into *_q_o. en_i=0 holds all registers.

## Timing
- Comb outputs: zero-cycle latency, settle within the same cycle as inputs.
- Registered outputs: 1-cycle latency after the en_i-qualified edge.
- Reset (rst_ni=0, asynchronous assertion, any time including mid-capture): all *_q_o and valid_q_o -> 0 immediately; held 0 while low. Release synchronous to clk_i; first capture on first enabled edge after release.
- en_i=1 with illegal encoding captures valid_q_o=0 and all *_q_o=0 (not hold).
- No handshake; no back-pressure; decoder never stalls.

## Structure
- Shared package rv32m_pkg: OPCODE_OP = 7'b0110011, FUNCT7_MULDIV = 7'b0000001, funct3 enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), and a packed ctrl struct {mult_on, div_on, signed_A, signed_B, upper_rem}.
- One comb always block / function producing the ctrl struct; one always_ff with async reset for the register stage. No sub-modules.

## Test plan
- opcode=0111011, funct7=0000001, funct3=000 -> all comb outputs 0.
- opcode=0110011, funct7=0100001, funct3=000 -> all 0; both fields invalid -> all 0.
- Legal opcode/funct7, sweep funct3 000..111 -> exact rows of the Operation list (e.g. 010 -> 1,0,1,0,1; 111 -> 0,1,0,0,1); check mutual exclusion.
- en_i=1, funct3=001 legal, one edge -> valid_q_o=1, mult_on_q_o=1, upper_rem_q_o=1; then en_i=0, change to DIV -> registers hold.
- Assert rst_ni low between edges after a legal capture -> all registered outputs 0 immediately, comb outputs unaffected.
- en_i=1 with illegal funct7 after a legal capture -> next edge valid_q_o=0, all *_q_o=0.
